load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter READ_LATENCY, default 1: responder clock edges between the address being presented and read data being valid on bus_data; legal range 1-15.
REQ-002 The block SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  in  1: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req  in  1: core access request, sampled only when accepting.
REQ-005 The block SHALL have port req_we  in  1: 1 = store, 0 = load.
REQ-006 The block SHALL have port req_size  in  2: 01 byte, 10 half, 11 word, 00 illegal.
REQ-007 The block SHALL have port req_signed  in  1: for loads, 1 = sign-extend, 0 = zero-extend.
REQ-008 The block SHALL have port req_addr  in  32: byte address.
REQ-009 The block SHALL have port req_wdata  in  32: store data, right-justified.
REQ-010 The block SHALL have port busy  out  1: high in states ACCESS and FAULT.
REQ-011 The block SHALL have port done  out  1: one-cycle completion pulse.
REQ-012 The block SHALL have port fault  out  1: valid with done; 1 = misaligned or illegal size.
REQ-013 The block SHALL have port rdata  out  32: extended load result, held until the next done.
REQ-014 The block SHALL have port bus_addr  out  32: bus address.
REQ-015 The block SHALL have port bus_rw  out  1: 1 = write, 0 = read.
REQ-016 The block SHALL have port bus_size  out  2: 00 idle, 01/10/11 as req_size.
REQ-017 The block SHALL have port bus_data  inout  32: driven only during write ACCESS, otherwise high-Z.

Function
REQ-018 All bus_* outputs SHALL be driven from flops; when the block is not in ACCESS, bus_size SHALL be 00, bus_rw 0, bus_addr 0 and bus_data Z.
REQ-019 The FSM SHALL have exactly the states IDLE, ACCESS, FAULT and DONE.
REQ-020 In IDLE or DONE with req=1, the block SHALL latch we, size, signed, addr and wdata at that edge; a legal, aligned request SHALL then go to ACCESS, and any other request SHALL go to FAULT.
REQ-021 A request SHALL be illegal if size=00, half with addr[0]=1, or word with addr[1:0]!=00.
REQ-022 In IDLE or DONE with req=0, the FSM SHALL go to IDLE.
REQ-023 req asserted in ACCESS or FAULT SHALL be ignored and not queued.
REQ-024 In ACCESS, bus_addr, bus_size and bus_rw SHALL reflect the latched request for the whole state.
REQ-025 A write SHALL stay in ACCESS exactly 1 cycle and drive bus_data: byte {24'b0, wdata[7:0]}, half {16'b0, wdata[15:0]}, word wdata.
REQ-026 A read SHALL stay in ACCESS exactly READ_LATENCY+1 cycles, tracked by a 4-bit counter cleared on entry.
REQ-027 A read SHALL sample bus_data at the edge that ends ACCESS.
REQ-028 Read data arrives right-justified; byte SHALL extend bit 7 and half SHALL extend bit 15, with 1s if signed and 0s otherwise; word SHALL pass through unchanged.
REQ-029 ACCESS SHALL go to DONE; in DONE, done=1, fault=0 and rdata SHALL be updated for reads.
REQ-030 Writes SHALL leave rdata unchanged.
REQ-031 FAULT SHALL last 1 cycle with no bus activity, then go to DONE with done=1 and fault=1; rdata SHALL be unchanged.
REQ-032 fault SHALL be 0 whenever done=0.
REQ-033 Latency: a read accepted at edge E0 SHALL give done=1 in the cycle after edge E0+READ_LATENCY+1; a write SHALL give done=1 in the cycle after edge E0+1.

Reset
REQ-034 rst=1 SHALL immediately, without waiting for clk, set state IDLE, counter 0, busy 0, done 0, fault 0, rdata 0, bus_size 00, bus_rw 0, bus_addr 0 and bus_data Z.
REQ-035 Reset during ACCESS SHALL abort the access with no done pulse.
REQ-036 After rst deasserts, the first rising clk edge SHALL be able to accept a request.

Verification
REQ-037 Word read, addr 0x0000_0004, READ_LATENCY=1, responder returns 0x0000_0113 -> bus_size=11 and bus_rw=0 for 2 cycles; done=1 after 3 cycles; rdata=0x0000_0113; fault=0.
REQ-038 Byte read, responder returns 0x0000_00B7 -> signed gives rdata=0xFFFF_FFB7; unsigned gives rdata=0x0000_00B7.
REQ-039 Half write, addr 0x8000_0002, wdata 0x1234_ABCD -> one cycle with bus_rw=1, bus_size=10, bus_data=0x0000_ABCD; then done=1; rdata unchanged.
REQ-040 Word read at 0x8000_0002 -> bus_size stays 00; done=1 and fault=1 in the cycle after FAULT.
REQ-041 rst pulsed mid read ACCESS -> bus_size=00 and bus_data=Z in the same cycle; no done pulse; next request completes normally.
REQ-042 req held high throughout -> ignored while busy; accepted again in the DONE cycle, giving back-to-back accesses with no IDLE gap.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core access at a time, runs it on a simple
// tri-state bus with a fixed read latency and returns an extended load result.
module load_store_unit #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic [31:0] bus_addr,
    output logic        bus_rw,
    output logic [1:0]  bus_size,
    inout  wire  [31:0] bus_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, FAULT, DONE} state_t;

    localparam logic [3:0] LAT_W = 4'(READ_LATENCY);

    state_t      state_q;
    logic        we_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        fault_q;
    logic [31:0] rdata_q;
    logic [31:0] bus_addr_q;
    logic        bus_rw_q;
    logic [1:0]  bus_size_q;
    logic        bus_oe_q;
    logic [31:0] bus_wdata_q;

    logic        req_legal;
    logic        last_cycle;

    function automatic logic [31:0] align_store(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b01:   return {24'b0, wdata[7:0]};
            2'b10:   return {16'b0, wdata[15:0]};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [1:0] size, input logic sgn,
                                                input logic [31:0] d);
        case (size)
            2'b01:   return {{24{sgn & d[7]}}, d[7:0]};
            2'b10:   return {{16{sgn & d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    always_comb begin
        case (req_size)
            2'b00:   req_legal = 1'b0;
            2'b10:   req_legal = ~req_addr[0];
            2'b11:   req_legal = (req_addr[1:0] == 2'b00);
            default: req_legal = 1'b1;
        endcase
    end

    // Writes complete after one bus cycle; reads after READ_LATENCY+1 cycles.
    assign last_cycle = we_q || (cnt_q == LAT_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            signed_q    <= 1'b0;
            size_q      <= 2'b00;
            cnt_q       <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= 32'd0;
            bus_addr_q  <= 32'd0;
            bus_rw_q    <= 1'b0;
            bus_size_q  <= 2'b00;
            bus_oe_q    <= 1'b0;
            bus_wdata_q <= 32'd0;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (req) begin
                        we_q     <= req_we;
                        signed_q <= req_signed;
                        size_q   <= req_size;
                        cnt_q    <= 4'd0;
                        busy_q   <= 1'b1;
                        if (req_legal) begin
                            state_q     <= ACCESS;
                            bus_addr_q  <= req_addr;
                            bus_rw_q    <= req_we;
                            bus_size_q  <= req_size;
                            bus_oe_q    <= req_we;
                            bus_wdata_q <= align_store(req_size, req_wdata);
                        end else begin
                            state_q <= FAULT;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (last_cycle) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        bus_addr_q  <= 32'd0;
                        bus_rw_q    <= 1'b0;
                        bus_size_q  <= 2'b00;
                        bus_oe_q    <= 1'b0;
                        bus_wdata_q <= 32'd0;
                        if (!we_q) begin
                            rdata_q <= extend_load(size_q, signed_q, bus_data);
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                FAULT: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    fault_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign fault    = fault_q;
    assign rdata    = rdata_q;
    assign bus_addr = bus_addr_q;
    assign bus_rw   = bus_rw_q;
    assign bus_size = bus_size_q;
    assign bus_data = bus_oe_q ? bus_wdata_q : 32'bz;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic, checked
// against a transaction-level model of access timing, bus contents and results.
module tb_load_store_unit;

    localparam int RL = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        busy, done, fault, bus_rw;
    logic [31:0] rdata, bus_addr;
    logic [1:0]  bus_size;
    wire  [31:0] bus_data;
    logic [31:0] rsp_val = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_rdata = 32'd0;

    // Responder drives read data whenever a read is on the bus.
    assign bus_data = (bus_size != 2'b00 && !bus_rw) ? rsp_val : 32'bz;

    load_store_unit #(.READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .fault(fault), .rdata(rdata),
        .bus_addr(bus_addr), .bus_rw(bus_rw), .bus_size(bus_size), .bus_data(bus_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd3) ? 4 : (sz == 2'd2) ? 2 : 1;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                               input logic [31:0] v);
        longint unsigned r;
        if (sz == 2'd3) return v;
        r = v % (longint'(1) << (8 * nbytes(sz)));
        if (sg && r >= (longint'(1) << (8 * nbytes(sz) - 1)))
            r = r + 64'h1_0000_0000 - (longint'(1) << (8 * nbytes(sz)));
        return 32'(r);
    endfunction

    function automatic logic [31:0] model_store(input logic [1:0] sz, input logic [31:0] v);
        if (sz == 2'd3) return v;
        return 32'(longint'(v) % (longint'(1) << (8 * nbytes(sz))));
    endfunction

    // One access, issued from the current cycle; returns in its DONE cycle.
    task automatic do_txn(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ad, input logic [31:0] wd,
                          input logic [31:0] rv, input bit hold);
        bit ok;
        int nacc;
        ok = (sz != 2'd0) && ((ad % nbytes(sz)) == 0);
        req = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = ad; req_wdata = wd; rsp_val = rv;
        step();
        if (hold) begin
            req_we = ~we; req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
        end else begin
            req = 1'b0;
        end
        if (!ok) begin
            chk("flt_busy", busy, 1);
            chk("flt_bus_size", bus_size, 0);
            chk("flt_bus_rw", bus_rw, 0);
            chk("flt_bus_addr", bus_addr, 0);
            chk("flt_done", done, 0);
            chk("flt_fault_early", fault, 0);
            step();
        end else begin
            nacc = we ? 1 : RL + 1;
            for (int c = 0; c < nacc; c++) begin
                chk("acc_busy", busy, 1);
                chk("acc_bus_size", bus_size, sz);
                chk("acc_bus_rw", bus_rw, we);
                chk("acc_bus_addr", bus_addr, ad);
                chk("acc_done", done, 0);
                chk("acc_fault", fault, 0);
                if (we) chk("acc_bus_data", bus_data, model_store(sz, wd));
                step();
            end
            if (!we) exp_rdata = model_load(sz, sg, rv);
        end
        chk("done", done, 1);
        chk("fault", fault, ok ? 0 : 1);
        chk("done_busy", busy, 0);
        chk("done_bus_size", bus_size, 0);
        chk("rdata", rdata, exp_rdata);
    endtask

    initial begin
        bit held;
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_bus_size", bus_size, 0);
        chk("rst_bus_addr", bus_addr, 0);
        step();
        rst = 1'b0;

        // Word read, signed/unsigned byte reads, half write, misaligned word read
        do_txn(1'b0, 2'b11, 1'b0, 32'h0000_0004, 32'h0, 32'h0000_0113, 1'b0);
        do_txn(1'b0, 2'b01, 1'b1, 32'h0000_0011, 32'h0, 32'h0000_00B7, 1'b0);
        do_txn(1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0, 32'h0000_00B7, 1'b0);
        do_txn(1'b1, 2'b10, 1'b0, 32'h8000_0002, 32'h1234_ABCD, 32'h0, 1'b0);
        do_txn(1'b0, 2'b11, 1'b0, 32'h8000_0002, 32'h0, 32'hDEAD_BEEF, 1'b0);
        do_txn(1'b0, 2'b10, 1'b1, 32'h0000_0102, 32'h0, 32'h5555_8001, 1'b0);
        do_txn(1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 1'b0);
        step();
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);

        // Reset in the middle of a read access
        req = 1'b1; req_we = 1'b0; req_size = 2'b11; req_addr = 32'h40; rsp_val = 32'hCAFE_F00D;
        step();
        req = 1'b0;
        chk("mid_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_bus_size", bus_size, 0);
        chk("mid_busy", busy, 0);
        chk("mid_rdata", rdata, 0);
        exp_rdata = 32'd0;
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_no_done", done, 0);
        end
        do_txn(1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'h0, 32'h0BAD_F00D, 1'b0);

        // req held high: ignored while busy, back-to-back from DONE
        do_txn(1'b0, 2'b01, 1'b1, 32'h3, 32'h0, 32'h0000_0080, 1'b1);
        do_txn(1'b1, 2'b11, 1'b0, 32'h10, 32'hA5A5_5A5A, 32'h0, 1'b1);
        do_txn(1'b0, 2'b11, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
        do_txn(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h1234_FEDC, 1'b0);

        held = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (!held && ($urandom % 4) == 0) begin
                step();
                chk("rnd_idle_busy", busy, 0);
                chk("rnd_idle_fault", fault, 0);
            end
            held = (($urandom % 5) == 0);
            do_txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom, held);
        end
        req = 1'b0;
        step();
        chk("end_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
